// File: rtl/mycpu_pkg.sv
// Shared definitions for the data-side request path: FSM state encoding and
// access-size codes used on the exe-stage request interface.
package mycpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } dmem_state_e;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  // Captured request fields, held stable on the bus until it is accepted.
  typedef struct packed {
    logic        op;     // 1 = store, 0 = load
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dmem_req_t;

  // Bus size code is the low two bits of the request size; bit 2 carries nothing.
  function automatic logic [1:0] bus_size_of(input logic [2:0] size);
    return size[1:0];
  endfunction

endpackage

// File: rtl/dmem_req_responder.sv
// Responder for the exe-stage data request interface: accepts one request at a
// time, issues it as a single bus transaction and pulses completion to mem.
module dmem_req_responder
  import mycpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  data_valid,
  input  logic                  data_op,
  input  logic [2:0]            data_size,
  input  logic [3:0]            data_wstrb,
  input  logic [31:0]           data_wdata,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [31:0]           data_rdata,

  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [3:0]            bus_wstrb,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [31:0]           bus_rdata
);

  dmem_state_e           state_q, state_d;
  dmem_req_t             req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  data_ok_q;
  logic [31:0]           rdata_q;
  logic                  accept;
  logic                  complete;
  logic                  unused_size_bit;

  // Only the low two size bits reach the bus; the top bit is don't-care.
  assign unused_size_bit = data_size[2];

  // Acceptance is purely combinational so the exe stage sees it in the same cycle.
  assign accept       = (state_q == ST_IDLE) && data_valid;
  assign complete     = (state_q == ST_WAIT) && bus_data_ok;
  assign data_addr_ok = accept;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (data_valid)  state_d = ST_REQ;
      ST_REQ:  if (bus_addr_ok) state_d = ST_WAIT;
      ST_WAIT: if (bus_data_ok) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      data_ok_q <= complete;
      if (accept) begin
        req_q.op    <= data_op;
        req_q.size  <= bus_size_of(data_size);
        req_q.wstrb <= data_wstrb;
        req_q.wdata <= data_wdata;
        addr_q      <= data_addr;
      end
      // A store completion leaves the last load word visible.
      if (complete && !req_q.op) rdata_q <= bus_rdata;
    end
  end

  assign bus_req      = (state_q == ST_REQ);
  assign bus_wr       = req_q.op;
  assign bus_size     = req_q.size;
  assign bus_wstrb    = req_q.op ? req_q.wstrb : 4'b0000;
  assign bus_addr     = addr_q;
  assign bus_wdata    = req_q.wdata;

  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_req_responder.sv
// Directed bench for dmem_req_responder: a cycle-by-cycle vector table followed
// by hand-written sequences for stalls, busy requests, stray responses and reset.
module tb_dmem_req_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_valid, data_op;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata, data_addr;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_req_responder #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .data_valid(data_valid), .data_op(data_op), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr(data_addr),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rst, dv, op;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata, addr;
    logic        baok, bdok;
    logic [31:0] brdata;
    logic        e_aok, e_dok;
    logic [31:0] e_rdata;
    logic        e_breq, e_bwr;
    logic [1:0]  e_bsize;
    logic [3:0]  e_bwstrb;
    logic [31:0] e_baddr, e_bwdata;
  } vec_t;

  function automatic vec_t v(
    input logic rst, dv, op, input logic [2:0] size, input logic [3:0] wstrb,
    input logic [31:0] wdata, addr, input logic baok, bdok, input logic [31:0] brdata,
    input logic e_aok, e_dok, input logic [31:0] e_rdata, input logic e_breq, e_bwr,
    input logic [1:0] e_bsize, input logic [3:0] e_bwstrb, input logic [31:0] e_baddr, e_bwdata);
    vec_t r;
    r.rst = rst; r.dv = dv; r.op = op; r.size = size; r.wstrb = wstrb;
    r.wdata = wdata; r.addr = addr; r.baok = baok; r.bdok = bdok; r.brdata = brdata;
    r.e_aok = e_aok; r.e_dok = e_dok; r.e_rdata = e_rdata; r.e_breq = e_breq;
    r.e_bwr = e_bwr; r.e_bsize = e_bsize; r.e_bwstrb = e_bwstrb;
    r.e_baddr = e_baddr; r.e_bwdata = e_bwdata;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic dv, input logic op, input logic [2:0] size,
                           input logic [3:0] wstrb, input logic [31:0] wdata,
                           input logic [31:0] addr);
    data_valid = dv; data_op = op; data_size = size;
    data_wstrb = wstrb; data_wdata = wdata; data_addr = addr;
  endtask

  task automatic drive_bus(input logic baok, input logic bdok, input logic [31:0] rdata);
    bus_addr_ok = baok; bus_data_ok = bdok; bus_rdata = rdata;
  endtask

  // Answers the outstanding request with a one-cycle-per-phase bus and waits,
  // within a cycle budget, for the completion pulse.
  task automatic complete_txn(input string name, input logic [31:0] rdata,
                              input logic [31:0] exp_rdata);
    bit acked = 0;
    bit got   = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      drive_req(1'b0, 1'b0, 3'b000, 4'h0, 32'h0, 32'h0);
      drive_bus(bus_req, acked && !bus_req, rdata);
      if (bus_req) acked = 1;
      #1;
      if (data_data_ok) got = 1;
    end
    check({name, " completion seen"}, {31'd0, got}, 32'd1);
    check({name, " rdata"}, data_rdata, exp_rdata);
    drive_bus(1'b0, 1'b0, 32'h0);
  endtask

  vec_t vecs [19];

  initial begin
    vecs[0]  = v(1,0,0,3'b000,4'h0,32'h0,32'h0,          0,0,32'h0,        0,0,32'h0,        0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[1]  = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,0,32'h0,        0,0,32'h0,        0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[2]  = v(0,1,0,3'b010,4'hF,32'h12345678,32'h1C000100, 0,0,32'h0,   1,0,32'h0,        0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[3]  = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          1,0,32'h0,        0,0,32'h0,        1,0,2'b10,4'h0,32'h1C000100,32'h12345678);
    vecs[4]  = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,1,32'hDEADBEEF, 0,0,32'h0,        0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[5]  = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,0,32'h0,        0,1,32'hDEADBEEF, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[6]  = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,0,32'h0,        0,0,32'hDEADBEEF, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[7]  = v(0,1,1,3'b000,4'b0100,32'h00AB0000,32'h80000002, 0,0,32'h0, 1,0,32'hDEADBEEF, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[8]  = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          1,0,32'h0,        0,0,32'hDEADBEEF, 1,1,2'b00,4'b0100,32'h80000002,32'h00AB0000);
    vecs[9]  = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,1,32'h55555555, 0,0,32'hDEADBEEF, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[10] = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,0,32'h0,        0,1,32'hDEADBEEF, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[11] = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,0,32'h0,        0,0,32'hDEADBEEF, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[12] = v(0,1,0,3'b101,4'b0011,32'h0,32'h00000006, 0,0,32'h0,       1,0,32'hDEADBEEF, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[13] = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          1,0,32'h0,        0,0,32'hDEADBEEF, 1,0,2'b01,4'h0,32'h00000006,32'h0);
    vecs[14] = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,1,32'hCAFE0000, 0,0,32'hDEADBEEF, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[15] = v(0,1,1,3'b010,4'hF,32'hA5A5A5A5,32'h00000010, 0,0,32'h0,   1,1,32'hCAFE0000, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[16] = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          1,0,32'h0,        0,0,32'hCAFE0000, 1,1,2'b10,4'hF,32'h00000010,32'hA5A5A5A5);
    vecs[17] = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,1,32'hFFFFFFFF, 0,0,32'hCAFE0000, 0,0,2'b00,4'h0,32'h0,32'h0);
    vecs[18] = v(0,0,0,3'b000,4'h0,32'h0,32'h0,          0,0,32'h0,        0,1,32'hCAFE0000, 0,0,2'b00,4'h0,32'h0,32'h0);

    reset = 1'b1;
    drive_req(1'b0, 1'b0, 3'b000, 4'h0, 32'h0, 32'h0);
    drive_bus(1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    // Cycle-accurate table: inputs apply after the falling edge, outputs checked 1ns later.
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      drive_req(vecs[i].dv, vecs[i].op, vecs[i].size, vecs[i].wstrb, vecs[i].wdata, vecs[i].addr);
      drive_bus(vecs[i].baok, vecs[i].bdok, vecs[i].brdata);
      #1;
      check($sformatf("v%0d addr_ok", i), {31'd0, data_addr_ok}, {31'd0, vecs[i].e_aok});
      check($sformatf("v%0d data_ok", i), {31'd0, data_data_ok}, {31'd0, vecs[i].e_dok});
      check($sformatf("v%0d rdata", i), data_rdata, vecs[i].e_rdata);
      check($sformatf("v%0d bus_req", i), {31'd0, bus_req}, {31'd0, vecs[i].e_breq});
      if (vecs[i].e_breq) begin
        check($sformatf("v%0d bus_wr", i), {31'd0, bus_wr}, {31'd0, vecs[i].e_bwr});
        check($sformatf("v%0d bus_size", i), {30'd0, bus_size}, {30'd0, vecs[i].e_bsize});
        check($sformatf("v%0d bus_wstrb", i), {28'd0, bus_wstrb}, {28'd0, vecs[i].e_bwstrb});
        check($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].e_baddr);
        check($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].e_bwdata);
      end
      @(negedge clk);
    end

    // Backpressure: addr_ok withheld 5 cycles, data_ok withheld 3; pulse lands at cycle 11.
    drive_req(1'b1, 1'b0, 3'b010, 4'h0, 32'h0, 32'h00002000);
    drive_bus(1'b0, 1'b0, 32'h0);
    #1 check("bp accept", {31'd0, data_addr_ok}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive_req(1'b0, 1'b1, 3'b000, 4'hF, 32'h11111111, 32'hFFFF0000);
      #1;
      check($sformatf("bp c%0d bus_req", c), {31'd0, bus_req}, 32'd1);
      check($sformatf("bp c%0d bus_addr", c), bus_addr, 32'h00002000);
      check($sformatf("bp c%0d bus_wr", c), {31'd0, bus_wr}, 32'd0);
      check($sformatf("bp c%0d bus_size", c), {30'd0, bus_size}, 32'd2);
      check($sformatf("bp c%0d data_ok", c), {31'd0, data_data_ok}, 32'd0);
    end
    @(negedge clk); drive_bus(1'b1, 1'b0, 32'h0);
    #1 check("bp c6 bus_req", {31'd0, bus_req}, 32'd1);
    for (int c = 7; c <= 9; c++) begin
      @(negedge clk); drive_bus(1'b0, 1'b0, 32'h0);
      #1;
      check($sformatf("bp c%0d bus_req", c), {31'd0, bus_req}, 32'd0);
      check($sformatf("bp c%0d data_ok", c), {31'd0, data_data_ok}, 32'd0);
    end
    @(negedge clk); drive_bus(1'b0, 1'b1, 32'h0BADF00D);
    #1 check("bp c10 data_ok", {31'd0, data_data_ok}, 32'd0);
    @(negedge clk); drive_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("bp c11 data_ok", {31'd0, data_data_ok}, 32'd1);
    check("bp c11 rdata", data_rdata, 32'h0BADF00D);
    @(negedge clk);
    #1 check("bp c12 data_ok", {31'd0, data_data_ok}, 32'd0);

    // Second request held while busy is only accepted on the completion cycle.
    @(negedge clk);
    drive_req(1'b1, 1'b1, 3'b010, 4'hF, 32'h11112222, 32'h00003000);
    #1 check("busy accept1", {31'd0, data_addr_ok}, 32'd1);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 4'h0, 32'h0, 32'h00004000);
    drive_bus(1'b1, 1'b0, 32'h0);
    #1;
    check("busy c1 addr_ok", {31'd0, data_addr_ok}, 32'd0);
    check("busy c1 bus_addr", bus_addr, 32'h00003000);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk); drive_bus(1'b0, 1'b0, 32'h0);
      #1 check($sformatf("busy c%0d addr_ok", c), {31'd0, data_addr_ok}, 32'd0);
    end
    @(negedge clk); drive_bus(1'b0, 1'b1, 32'h77777777);
    #1 check("busy c4 addr_ok", {31'd0, data_addr_ok}, 32'd0);
    @(negedge clk); drive_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("busy c5 data_ok", {31'd0, data_data_ok}, 32'd1);
    check("busy c5 addr_ok", {31'd0, data_addr_ok}, 32'd1);
    check("busy c5 rdata kept", data_rdata, 32'h0BADF00D);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'b000, 4'h0, 32'h0, 32'h0);
    #1;
    check("busy c6 bus_req", {31'd0, bus_req}, 32'd1);
    check("busy c6 bus_addr", bus_addr, 32'h00004000);
    check("busy c6 bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    complete_txn("busy second", 32'h00000099, 32'h00000099);

    // Stray bus_data_ok in IDLE and in REQ must not complete anything.
    @(negedge clk); drive_bus(1'b0, 1'b1, 32'hEEEEEEEE);
    #1 check("spur idle bus_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk); drive_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("spur idle data_ok", {31'd0, data_data_ok}, 32'd0);
    check("spur idle rdata", data_rdata, 32'h00000099);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b000, 4'h0, 32'h0, 32'h00005001);
    #1 check("spur accept", {31'd0, data_addr_ok}, 32'd1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'b000, 4'h0, 32'h0, 32'h0);
    drive_bus(1'b0, 1'b1, 32'hEEEEEEEE);
    #1 check("spur req bus_req", {31'd0, bus_req}, 32'd1);
    @(negedge clk); drive_bus(1'b0, 1'b0, 32'h0);
    #1;
    check("spur req still req", {31'd0, bus_req}, 32'd1);
    check("spur req data_ok", {31'd0, data_data_ok}, 32'd0);
    complete_txn("spur txn", 32'h000000AB, 32'h000000AB);

    // Reset while in WAIT drops the transaction without a completion pulse.
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 4'h0, 32'h0, 32'h00006000);
    #1 check("rst accept", {31'd0, data_addr_ok}, 32'd1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'b000, 4'h0, 32'h0, 32'h0);
    drive_bus(1'b1, 1'b0, 32'h0);
    #1 check("rst bus_req", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    drive_bus(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst after bus_req", {31'd0, bus_req}, 32'd0);
    check("rst after data_ok", {31'd0, data_data_ok}, 32'd0);
    check("rst after rdata", data_rdata, 32'h0);
    @(negedge clk);
    #1 check("rst later data_ok", {31'd0, data_data_ok}, 32'd0);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 4'h0, 32'h0, 32'h00007000);
    #1 check("rst new accept", {31'd0, data_addr_ok}, 32'd1);
    complete_txn("rst new txn", 32'h13572468, 32'h13572468);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
